// File: rtl/moore_seq_gen.sv
// Ring sequencer with one conditional forward skip, direction control and a wrap pulse.
// Define MOORE_SEQ_LAP_CNT_EN to build the saturating forward-lap counter; otherwise lap is tied to 0.
module moore_seq_gen #(
    parameter int NUM_STATES = 4,
    parameter int OUT_W      = 3,
    parameter int OUT_BASE   = 1,
    parameter int SKIP_FROM  = 1,
    parameter int SKIP_TO    = 3,
    parameter int LAP_W      = 8,
    localparam int SW        = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             control,
    input  logic             dir,
    input  logic             sync_clr,
    output logic [SW-1:0]    state,
    output logic [OUT_W-1:0] y,
    output logic             wrap,
    output logic [LAP_W-1:0] lap
);

    // state | meaning
    // 0     | ring start; reset and sync_clr target
    // k     | step k of the ring, 0 < k < NUM_STATES-1
    // LAST  | NUM_STATES-1; forward step from here wraps to 0
    localparam logic [SW-1:0]    LAST   = SW'(NUM_STATES - 1);
    localparam logic [SW-1:0]    S_FROM = SW'(SKIP_FROM);
    localparam logic [SW-1:0]    S_TO   = SW'(SKIP_TO);
    localparam logic [OUT_W-1:0] BASE   = OUT_W'(OUT_BASE);

    logic [SW-1:0] state_nxt;
    logic          step_wrap;

    always_comb begin
        state_nxt = state;
        step_wrap = 1'b0;
        if (dir) begin
            if (state == '0) begin
                state_nxt = LAST;
                step_wrap = 1'b1;
            end else begin
                state_nxt = state - 1'b1;
            end
        end else if (state == S_FROM && control) begin
            // a skip only counts as a wrap when it leaves the last state for 0
            state_nxt = S_TO;
            step_wrap = (state == LAST) && (S_TO == '0);
        end else if (state == LAST) begin
            state_nxt = '0;
            step_wrap = 1'b1;
        end else begin
            state_nxt = state + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
            wrap  <= 1'b0;
        end else if (sync_clr) begin
            state <= '0;
            wrap  <= 1'b0;
        end else if (enable) begin
            state <= state_nxt;
            wrap  <= step_wrap;
        end else begin
            wrap  <= 1'b0;
        end
    end

    assign y = OUT_W'(state) + BASE;

`ifdef MOORE_SEQ_LAP_CNT_EN
    logic [LAP_W-1:0] lap_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_q <= '0;
        end else if (sync_clr) begin
            lap_q <= '0;
        end else if (enable && step_wrap && !dir && lap_q != '1) begin
            lap_q <= lap_q + 1'b1;
        end
    end

    assign lap = lap_q;
`else
    assign lap = '0;
`endif

endmodule

// File: tb/tb_moore_seq_gen.sv
// Scoreboard bench for moore_seq_gen: default instance plus a 6-state instance sharing stimulus.
module tb_moore_seq_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic control = 1'b0;
    logic dir = 1'b0;
    logic sync_clr = 1'b0;

    logic [1:0] a_state;
    logic [2:0] a_y;
    logic       a_wrap;
    logic [7:0] a_lap;

    logic [2:0] b_state;
    logic [3:0] b_y;
    logic       b_wrap;
    logic [1:0] b_lap;

    always #5 clk = ~clk;

    moore_seq_gen dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .control(control),
        .dir(dir), .sync_clr(sync_clr),
        .state(a_state), .y(a_y), .wrap(a_wrap), .lap(a_lap)
    );

    moore_seq_gen #(
        .NUM_STATES(6), .OUT_W(4), .OUT_BASE(14), .SKIP_FROM(1), .SKIP_TO(3), .LAP_W(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .control(control),
        .dir(dir), .sync_clr(sync_clr),
        .state(b_state), .y(b_y), .wrap(b_wrap), .lap(b_lap)
    );

`ifdef MOORE_SEQ_LAP_CNT_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    typedef struct {
        int a_state; int a_y; int a_wrap; int a_lap;
        int b_state; int b_y; int b_wrap; int b_lap;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int ma_s = 0, ma_lap = 0, mb_s = 0, mb_lap = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level ring step: returns next index, wrap flag and forward-wrap flag.
    task automatic model_step(input int n, input int sf, input int st, input int s,
                              input bit en, input bit clr, input bit ctl, input bit d,
                              output int ns, output int w, output bit fw);
        fw = 1'b0;
        w  = 0;
        if (clr) ns = 0;
        else if (!en) ns = s;
        else if (d) begin
            ns = (s + n - 1) % n;
            w  = (s == 0) ? 1 : 0;
        end else begin
            ns = (s == sf && ctl) ? st : (s + 1) % n;
            fw = (s == n - 1) && (ns == 0);
            w  = fw ? 1 : 0;
        end
    endtask

    function automatic int next_lap(input int lap, input bit clr, input bit fw, input int lap_w);
        int lmax = (1 << lap_w) - 1;
        if (!LAP_ON || clr) return 0;
        if (fw && lap < lmax) return lap + 1;
        return lap;
    endfunction

    function automatic int y_of(input int s, input int base, input int w);
        return (s + base) % (1 << w);
    endfunction

    task automatic check_now(input string tag);
        check({tag, "_a_state"}, int'(a_state), ma_s);
        check({tag, "_a_y"},     int'(a_y),     y_of(ma_s, 1, 3));
        check({tag, "_a_wrap"},  int'(a_wrap),  0);
        check({tag, "_a_lap"},   int'(a_lap),   ma_lap);
        check({tag, "_b_y"},     int'(b_y),     y_of(mb_s, 14, 4));
        check({tag, "_b_lap"},   int'(b_lap),   mb_lap);
    endtask

    // One stimulus cycle: optional async reset pulse, then inputs for the coming edge.
    task automatic drive(input bit rst, input bit en, input bit clr, input bit ctl, input bit d);
        exp_t e;
        int ns, w;
        bit fw;
        @(negedge clk);
        if (rst) begin
            #1 reset_n = 1'b0;
            ma_s = 0; ma_lap = 0; mb_s = 0; mb_lap = 0;
            #1 check_now("async_rst");
            #1 reset_n = 1'b1;
        end
        enable = en; sync_clr = clr; control = ctl; dir = d;
        model_step(4, 1, 3, ma_s, en, clr, ctl, d, ns, w, fw);
        ma_lap = next_lap(ma_lap, clr, fw, 8);
        ma_s = ns;
        e.a_state = ns; e.a_y = y_of(ns, 1, 3); e.a_wrap = w; e.a_lap = ma_lap;
        model_step(6, 1, 3, mb_s, en, clr, ctl, d, ns, w, fw);
        mb_lap = next_lap(mb_lap, clr, fw, 2);
        mb_s = ns;
        e.b_state = ns; e.b_y = y_of(ns, 14, 4); e.b_wrap = w; e.b_lap = mb_lap;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_state", int'(a_state), e.a_state);
                check("a_y",     int'(a_y),     e.a_y);
                check("a_wrap",  int'(a_wrap),  e.a_wrap);
                check("a_lap",   int'(a_lap),   e.a_lap);
                check("b_state", int'(b_state), e.b_state);
                check("b_y",     int'(b_y),     e.b_y);
                check("b_wrap",  int'(b_wrap),  e.b_wrap);
                check("b_lap",   int'(b_lap),   e.b_lap);
            end
        end
    end

    initial begin : stimulus
        #3;
        check_now("reset");
        check("reset_b_state", int'(b_state), 0);
        check("reset_b_wrap",  int'(b_wrap),  0);
        #10 reset_n = 1'b1;

        // plain forward lap: y 2,3,4,1 with wrap on the return to 0
        repeat (4) drive(0, 1, 0, 0, 0);
        // skip branch 0 -> 1 -> 3 -> 0
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        // reverse lap
        drive(0, 1, 1, 0, 0);
        repeat (4) drive(0, 1, 0, 1, 1);
        // hold in state 2 for three cycles
        drive(0, 1, 1, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        // async reset pulse while in state 3, then sync_clr with enable in state 2
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        // long forward run saturates the 2-bit lap counter
        repeat (36) drive(0, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 3);
        end

        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
